cache_way_array: RTL
====================

Name: cache_way_array

Overview:
- Multi-way, byte-laned cache data array: the next generation of the single-way cache set.
- Holds NUM_WAYS ways; each way is DATA_WIDTH/8 byte-wide synchronous RAM banks.
- Supports line, byte, halfword and word accesses with valid/ready request and response handshakes.
- Sub-line accesses that cross a line boundary are split in hardware into two sequential beats, not merely flagged; sits between the LSU/fetch front-end and the tag/replacement logic.

Parameters:
- ADDR_WIDTH, 8, byte address width within one way.
- DATA_WIDTH, 128, line width in bits; multiple of 32.
- NUM_WAYS, 2, number of ways; power of two, ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_way_i  in  max(1,$clog2(NUM_WAYS))  target way.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_width_i  in  2  0 = line, 1 = byte, 2 = halfword, 3 = word.
- req_wdata_i  in  DATA_WIDTH  write data, right-justified.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_WIDTH  read data, right-justified, zero-extended.
- rsp_err_o  out  1  access rejected (qualified by rsp_valid_o).

Behaviour:
- Address decode:
  - NB = DATA_WIDTH/8, OFF = $clog2(NB).
  - Line index L = addr[ADDR_WIDTH-1:OFF]; offset o = addr[OFF-1:0].
  - Size S = NB, 1, 2 or 4 for widths 0–3.
- Errors: the request is rejected (no RAM write, rsp_err_o = 1, rdata 0) when either:
  - width 0 with o ≠ 0; or
  - o+S > NB and L is the last line (no wrap to line 0).
- States: IDLE, SPLIT.
- IDLE:
  - req_ready_o = 1.
  - An accepted aligned request (o+S ≤ NB) or an error request → stay IDLE.
  - An accepted crossing request (o+S > NB, not error) → SPLIT.
- SPLIT:
  - req_ready_o = 0; issue beat 2 → IDLE.
- Aligned access, accepted at cycle T:
  - RAM read/write of line L in cycle T.
  - Write: byte lanes o..o+S-1 of way req_way_i are enabled; write data is shifted left by 8·o.
  - rsp_valid_o = 1 at T+1.
  - Read: rsp_rdata_o = line >> 8·o, masked to S bytes.
  - Write: rsp_rdata_o = 0.
- Crossing access, accepted at T:
  - Beat 1 at T: line L, lanes o..NB-1.
  - Beat 2 at T+1: line L+1, lanes 0..(o+S-NB-1).
  - rsp_valid_o at T+2 only; read data is beat-1 bytes in low positions, beat-2 bytes above them.
  - Request fields are registered at T; input changes during SPLIT are ignored.
- Ways not selected are never written.
- Back-to-back: aligned requests are accepted every cycle, giving one response per cycle, in order.
- Reset (asynchronous, any cycle):
  - state = IDLE; rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0; req_ready_o = 1 once reset is released.
  - Reset asserted during SPLIT: beat 2 is never performed, and the beat-1 write persists (partial write is documented behaviour).
  - RAM contents are not reset (simulation initialises them to 0).
- Single RAM port per bank; a read returns the pre-write contents of the same cycle.

Test Plan:
All scenarios use DATA_WIDTH = 128, NUM_WAYS = 2, ADDR_WIDTH = 8 (16 lines × 16 B).
1. Aligned write/read: word write, way 1, addr 0x04, data 0xDEADBEEF; then byte read, way 1, addr 0x05 → rsp at T+1, rdata 0xBE. Same read on way 0 → 0x00.
2. Split word: write, way 0, addr 0x1E, data 0x11223344 → req_ready_o low for exactly one cycle. Line 1 bytes 14/15 = 44/33; line 2 bytes 0/1 = 22/11. Word read at 0x1E → 0x11223344 at T+2.
3. Misaligned line write at addr 0x08 → rsp at T+1, rsp_err_o = 1; line 0 unchanged on readback.
4. Last-line crossing: halfword write at 0xFF → rsp_err_o = 1, no RAM change, ready stays 1.
5. Pipelining: 8 aligned byte reads on consecutive cycles (addrs 0x00–0x07, prefilled 0x10–0x17) → rsp_valid_o high 8 consecutive cycles, data 0x10..0x17 in order.
6. Reset during SPLIT: after accepting a word write at 0x2F, assert rst_ni low in the SPLIT cycle → rsp_valid_o 0 and no response. Line 2 byte 15 is written; line 3 bytes 0–2 are unchanged; req_ready_o = 1 after release.

Source files
------------

// File: rtl/cache_way_array.sv
// Multi-way, byte-laned cache data array.
// Each way is NB byte-wide banks of LINES entries. Sub-line accesses that
// cross a line boundary run as two beats (IDLE -> SPLIT -> IDLE). Bank reads
// are folded into the response register, so a response appears one cycle
// after its last beat.
module cache_way_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WAYS   = 2
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic                                                req_valid_i,
    output logic                                                req_ready_o,
    input  logic                                                req_we_i,
    input  logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] req_way_i,
    input  logic [ADDR_WIDTH-1:0]                               req_addr_i,
    input  logic [1:0]                                          req_width_i,
    input  logic [DATA_WIDTH-1:0]                               req_wdata_i,
    output logic                                                rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                               rsp_rdata_o,
    output logic                                                rsp_err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int LW    = ADDR_WIDTH - OFF;
    localparam int LINES = 1 << LW;
    localparam int WW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int EW    = OFF + 2;

    localparam logic [EW-1:0] NB_E      = EW'(NB);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    // Builds a mask covering the low 'size' bytes of a line.
    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [EW-1:0] size);
        logic [DATA_WIDTH-1:0] m;
        m = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < NB; b++) begin
            if (EW'(b) < size) begin
                m[8*b +: 8] = 8'hFF;
            end else begin
                m[8*b +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    state_t                r_state;
    logic                  r_ready;
    logic                  r_we;
    logic [WW-1:0]         r_way;
    logic [LW-1:0]         r_line_next;
    logic [OFF-1:0]        r_off;
    logic [EW-1:0]         r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [LW-1:0]         w_line;
    logic [OFF-1:0]        w_off;
    logic [EW-1:0]         w_size;
    logic [EW-1:0]         w_end;
    logic [EW-1:0]         w_b2_end;
    logic                  w_over;
    logic                  w_err;
    logic                  w_cross;
    logic                  w_accept;

    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [WW-1:0]         w_mem_way;
    logic [LW-1:0]         w_mem_line;
    logic [NB-1:0]         w_lane_en;
    logic [DATA_WIDTH-1:0] w_wshift;
    logic [DATA_WIDTH-1:0] w_rline;
    logic [7:0]            w_bank_rd [NUM_WAYS][NB];

    // Decode the incoming request: line, offset, size and error class.
    always_comb begin
        w_line = req_addr_i[ADDR_WIDTH-1:OFF];
        w_off  = req_addr_i[OFF-1:0];
        case (req_width_i)
            2'd0:    w_size = NB_E;
            2'd1:    w_size = EW'(32'd1);
            2'd2:    w_size = EW'(32'd2);
            2'd3:    w_size = EW'(32'd4);
            default: w_size = NB_E;
        endcase
        w_end    = {2'b00, w_off} + w_size;
        w_over   = (w_end > NB_E);
        w_err    = ((req_width_i == 2'd0) && (w_off != {OFF{1'b0}})) ||
                   (w_over && (w_line == LAST_LINE));
        w_cross  = w_over && !w_err;
        w_accept = req_valid_i && (r_state == ST_IDLE);
        w_b2_end = {2'b00, r_off} + r_size - NB_E;
    end

    // Drive the shared bank port from either the new request or the second beat.
    always_comb begin
        w_mem_en   = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_way  = req_way_i;
        w_mem_line = w_line;
        w_lane_en  = {NB{1'b0}};
        w_wshift   = req_wdata_i << {w_off, 3'b000};
        if (r_state == ST_SPLIT) begin
            w_mem_en   = rst_ni;
            w_mem_we   = rst_ni && r_we;
            w_mem_way  = r_way;
            w_mem_line = r_line_next;
            w_wshift   = r_wdata >> {NB_E - {2'b00, r_off}, 3'b000};
            for (int b = 0; b < NB; b++) begin
                w_lane_en[b] = (EW'(b) < w_b2_end);
            end
        end else if (w_accept && !w_err) begin
            w_mem_en = rst_ni;
            w_mem_we = rst_ni && req_we_i;
            for (int b = 0; b < NB; b++) begin
                w_lane_en[b] = (EW'(b) >= {2'b00, w_off}) && (EW'(b) < w_end);
            end
        end else begin
            w_mem_en = 1'b0;
            w_mem_we = 1'b0;
        end
    end

    for (genvar g_w = 0; g_w < NUM_WAYS; g_w++) begin : g_way
        for (genvar g_b = 0; g_b < NB; g_b++) begin : g_bank
            logic [7:0] r_bank [LINES];

            // Byte bank write: only the selected way and enabled lane update.
            always_ff @(posedge clk_i) begin
                if (w_mem_we && (w_mem_way == WW'(g_w)) && w_lane_en[g_b]) begin
                    r_bank[w_mem_line] <= w_wshift[8*g_b +: 8];
                end
            end

            assign w_bank_rd[g_w][g_b] = r_bank[w_mem_line];
        end
    end

    // Gather the addressed line of the selected way (pre-write contents).
    always_comb begin
        w_rline = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < NB; b++) begin
            w_rline[8*b +: 8] = w_bank_rd[w_mem_way][b];
        end
    end

    // Request FSM, beat-2 capture and registered response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_way       <= {WW{1'b0}};
            r_line_next <= {LW{1'b0}};
            r_off       <= {OFF{1'b0}};
            r_size      <= {EW{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_acc       <= {DATA_WIDTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_err) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                    end else if (w_accept && w_cross) begin
                        r_state     <= ST_SPLIT;
                        r_ready     <= 1'b0;
                        r_we        <= req_we_i;
                        r_way       <= req_way_i;
                        r_line_next <= w_line + {{(LW-1){1'b0}}, 1'b1};
                        r_off       <= w_off;
                        r_size      <= w_size;
                        r_wdata     <= req_wdata_i;
                        r_acc       <= w_rline >> {w_off, 3'b000};
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end else if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= req_we_i ? {DATA_WIDTH{1'b0}}
                                     : ((w_rline >> {w_off, 3'b000}) & byte_mask(w_size));
                    end else begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                ST_SPLIT: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? {DATA_WIDTH{1'b0}}
                                 : ((r_acc | (w_rline << {NB_E - {2'b00, r_off}, 3'b000}))
                                    & byte_mask(r_size));
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule
